// File: rtl/pipeline_sequencer.sv
// Six-phase instruction pipeline sequencer with run/halt control, memory and
// execute-unit stalls, fetch timeout fault and a retired-instruction counter.
// Build option: define PIPELINE_SINGLE_STEP_EN to halt after every instruction.
module pipeline_sequencer #(
   parameter int FETCH_TIMEOUT = 255,
   parameter int RETIRE_W      = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                halt_req,
   input  logic                fetch_ack,
   input  logic                exec_done,
   output logic                fetch_req_state,
   output logic                fetch_rcv_state,
   output logic                decode_state,
   output logic                setup_state,
   output logic                execute_state,
   output logic                writeback_state,
   output logic                running,
   output logic                halted,
   output logic                fault,
   output logic [RETIRE_W-1:0] retired_count
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_FETCH_REQ  = 4'd1,
      S_FETCH_RECV = 4'd2,
      S_DECODE     = 4'd3,
      S_SETUP      = 4'd4,
      S_EXECUTE    = 4'd5,
      S_WRITEBACK  = 4'd6,
      S_HALTED     = 4'd7,
      S_FAULT      = 4'd8
   } state_t;

   // wait counter is sized for the widest legal timeout (65535)
   localparam logic [15:0] WAIT_LAST = 16'(FETCH_TIMEOUT - 1);

   state_t              state_q;
   logic [15:0]         wait_cnt_q;
   logic                halt_pending_q;
   logic [RETIRE_W-1:0] retired_q;
   logic                halt_at_wb_d;

   // Decide whether the instruction now in WRITEBACK is the last one
`ifdef PIPELINE_SINGLE_STEP_EN
   // every instruction boundary stops; the pending flag is kept for symmetry
   assign halt_at_wb_d = halt_pending_q | 1'b1;
`else
   assign halt_at_wb_d = halt_pending_q | halt_req;
`endif

   // Sequencer state, fetch wait counter, halt latch and retire counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         wait_cnt_q     <= 16'd0;
         halt_pending_q <= 1'b0;
         retired_q      <= '0;
      end else begin
         // any halt request seen mid-instruction is remembered until HALTED
         if (running && halt_req) begin
            halt_pending_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_FETCH_REQ;
               end
            end
            S_FETCH_REQ: begin
               state_q    <= S_FETCH_RECV;
               wait_cnt_q <= 16'd0;
            end
            S_FETCH_RECV: begin
               // an ack in the final allowed cycle still wins over the timeout
               if (fetch_ack) begin
                  state_q <= S_DECODE;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  state_q <= S_FAULT;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 16'd1;
               end
            end
            S_DECODE: begin
               state_q <= S_SETUP;
            end
            S_SETUP: begin
               state_q <= S_EXECUTE;
            end
            S_EXECUTE: begin
               if (exec_done) begin
                  state_q <= S_WRITEBACK;
               end
            end
            S_WRITEBACK: begin
               retired_q <= retired_q + RETIRE_W'(1);
               if (halt_at_wb_d) begin
                  state_q        <= S_HALTED;
                  halt_pending_q <= 1'b0;
               end else begin
                  state_q <= S_FETCH_REQ;
               end
            end
            S_HALTED: begin
               if (start) begin
                  state_q <= S_FETCH_REQ;
               end
            end
            S_FAULT: begin
               state_q <= S_FAULT;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Phase enables and status decoded straight from the state register
   always_comb begin
      fetch_req_state = (state_q == S_FETCH_REQ);
      fetch_rcv_state = (state_q == S_FETCH_RECV);
      decode_state    = (state_q == S_DECODE);
      setup_state     = (state_q == S_SETUP);
      execute_state   = (state_q == S_EXECUTE);
      writeback_state = (state_q == S_WRITEBACK);
      running         = fetch_req_state | fetch_rcv_state | decode_state |
                        setup_state | execute_state | writeback_state;
      halted          = (state_q == S_HALTED);
      fault           = (state_q == S_FAULT);
      retired_count   = retired_q;
   end

endmodule
